pong_score_fsm: RTL and testbench

Match controller for the pong game: sits downstream of the game datapath, consuming its per-frame tick and ball-exit events. It keeps both scores in BCD, sequences serve / rally / inter-point pause / game-over, and feeds back a motion enable and serve command/direction to the ball and paddle logic. Score outputs drive the seven-segment/LED display stage.

---
 rtl/pong_pkg.sv | 18 +
 rtl/bcd_counter_2d.sv | 49 ++++
 rtl/pong_score_fsm.sv | 149 ++++++++++++++
 tb/tb_pong_score_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_PC     = 2'b10;

    localparam int DEFAULT_WIN_SCORE    = 11;
    localparam int DEFAULT_PAUSE_FRAMES = 60;

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD score counter with a parallel binary count for win compares.
module bcd_counter_2d (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] bcd_o,
    output logic [6:0] bin_o
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [6:0] bin_q, bin_d;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        bin_d  = bin_q;
        if (clr_i) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            bin_d  = 7'd0;
        end else if (inc_i) begin
            bin_d = bin_q + 7'd1;
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            bin_q  <= 7'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            bin_q  <= bin_d;
        end
    end

    assign bcd_o = {tens_q, ones_q};
    assign bin_o = bin_q;

endmodule

// File: rtl/pong_score_fsm.sv
// Pong match controller: scoring, serve sequencing and inter-point pause.
// state | meaning
// IDLE  | waiting for first start press after reset
// PLAY  | ball in motion, misses score
// PAUSE | frozen for PAUSE_FRAMES frame ticks, then serve
// OVER  | a side reached WIN_SCORE; wait for start press
module pong_score_fsm
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
    parameter int PAUSE_FRAMES = DEFAULT_PAUSE_FRAMES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_tick_i,
    input  logic       start_i,
    input  logic       miss_player_i,
    input  logic       miss_pc_i,
    output logic       play_en_o,
    output logic       serve_o,
    output logic       serve_dir_o,
    output logic [7:0] score_player_o,
    output logic [7:0] score_pc_o,
    output logic [1:0] winner_o,
    output logic [1:0] state_o
);

    localparam logic [6:0] WIN_BIN   = 7'(WIN_SCORE);
    localparam logic [7:0] PAUSE_LDV = 8'(PAUSE_FRAMES);

    game_state_e state_q, state_d;
    logic        play_en_q, play_en_d;
    logic        serve_q, serve_d;
    logic        serve_dir_q, serve_dir_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  pause_cnt_q, pause_cnt_d;
    logic        start_q, start_d;

    logic        start_rise;
    logic        score_clr, inc_player, inc_pc;
    logic [6:0]  bin_player, bin_pc;

    assign start_rise = start_i & ~start_q;

    always_comb begin
        state_d     = state_q;
        play_en_d   = play_en_q;
        serve_d     = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        pause_cnt_d = pause_cnt_q;
        start_d     = start_i;
        score_clr   = 1'b0;
        inc_player  = 1'b0;
        inc_pc      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                play_en_d = 1'b0;
                if (start_rise) begin
                    score_clr = 1'b1;
                    winner_d  = WIN_NONE;
                    serve_d   = 1'b1;
                    play_en_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                play_en_d = 1'b1;
                if (miss_pc_i || miss_player_i) begin
                    play_en_d   = 1'b0;
                    state_d     = ST_PAUSE;
                    pause_cnt_d = PAUSE_LDV;
                    // A simultaneous double miss is a void point: pause, no score.
                    if (miss_pc_i && !miss_player_i) begin
                        inc_player  = 1'b1;
                        serve_dir_d = 1'b1;
                        if (bin_player + 7'd1 == WIN_BIN) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_PLAYER;
                        end
                    end else if (miss_player_i && !miss_pc_i) begin
                        inc_pc      = 1'b1;
                        serve_dir_d = 1'b0;
                        if (bin_pc + 7'd1 == WIN_BIN) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_PC;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                play_en_d = 1'b0;
                if (pause_cnt_q == 8'd0) begin
                    serve_d   = 1'b1;
                    play_en_d = 1'b1;
                    state_d   = ST_PLAY;
                end else if (frame_tick_i) begin
                    pause_cnt_d = pause_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            play_en_q   <= 1'b0;
            serve_q     <= 1'b0;
            serve_dir_q <= 1'b0;
            winner_q    <= WIN_NONE;
            pause_cnt_q <= 8'd0;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            play_en_q   <= play_en_d;
            serve_q     <= serve_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            pause_cnt_q <= pause_cnt_d;
            start_q     <= start_d;
        end
    end

    bcd_counter_2d u_score_player (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (score_clr),
        .inc_i  (inc_player),
        .bcd_o  (score_player_o),
        .bin_o  (bin_player)
    );

    bcd_counter_2d u_score_pc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (score_clr),
        .inc_i  (inc_pc),
        .bcd_o  (score_pc_o),
        .bin_o  (bin_pc)
    );

    assign play_en_o   = play_en_q;
    assign serve_o     = serve_q;
    assign serve_dir_o = serve_dir_q;
    assign winner_o    = winner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pong_score_fsm.sv
// Scoreboard bench for pong_score_fsm with WIN_SCORE=11, PAUSE_FRAMES=2.
module tb_pong_score_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, start, miss_player, miss_pc;
    logic       play_en, serve, serve_dir;
    logic [7:0] score_player, score_pc;
    logic [1:0] winner, state;

    int n_cmp = 0;
    int n_err = 0;

    int m_player = 0;
    int m_pc     = 0;
    int m_dir    = 0;

    typedef struct {
        logic [7:0] sp;
        logic [7:0] spc;
        logic [1:0] st;
        logic [1:0] win;
        logic       dir;
        logic       en;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pong_score_fsm #(.WIN_SCORE(11), .PAUSE_FRAMES(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_tick_i   (frame_tick),
        .start_i        (start),
        .miss_player_i  (miss_player),
        .miss_pc_i      (miss_pc),
        .play_en_o      (play_en),
        .serve_o        (serve),
        .serve_dir_o    (serve_dir),
        .score_player_o (score_player),
        .score_pc_o     (score_pc),
        .winner_o       (winner),
        .state_o        (state)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] win, input logic en);
        exp_t e;
        e.sp  = to_bcd(m_player);
        e.spc = to_bcd(m_pc);
        e.st  = st;
        e.win = win;
        e.dir = m_dir[0];
        e.en  = en;
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sp"},  32'(score_player), 32'(e.sp));
            chk({tag, "_spc"}, 32'(score_pc),     32'(e.spc));
            chk({tag, "_st"},  32'(state),        32'(e.st));
            chk({tag, "_win"}, 32'(winner),       32'(e.win));
            chk({tag, "_dir"}, 32'(serve_dir),    32'(e.dir));
            chk({tag, "_en"},  32'(play_en),      32'(e.en));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered PAUSE with counter at 2: expects serve exactly one cycle after the second tick.
    task automatic pause_serve(input string tag);
        step();
        chk({tag, "_noserve0"}, 32'(serve), 32'd0);
        chk({tag, "_hold"},     32'(state), 32'd2);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk({tag, "_noserve1"}, 32'(serve), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk({tag, "_noserve2"}, 32'(serve), 32'd0);
        step();
        chk({tag, "_serve"},    32'(serve), 32'd1);
        chk({tag, "_srv_dir"},  32'(serve_dir), 32'(m_dir));
        chk({tag, "_srv_en"},   32'(play_en), 32'd1);
        chk({tag, "_srv_st"},   32'(state), 32'd1);
        step();
        chk({tag, "_serve_end"}, 32'(serve), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1;
        frame_tick = 1'b0; miss_player = 1'b0; miss_pc = 1'b0;
        #13;
        push(2'd0, 2'b00, 1'b0);
        check_pop("rst");
        chk("rst_serve", 32'(serve), 32'd0);
        rst_n = 1'b1;

        // Start held through reset must not start a game.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_noserve", 32'(serve), 32'd0);
        end
        chk("held_idle", 32'(state), 32'd0);

        start = 1'b0; step();
        start = 1'b1; step();
        push(2'd1, 2'b00, 1'b1);
        check_pop("start");
        chk("start_serve", 32'(serve), 32'd1);
        step();
        chk("start_serve_end", 32'(serve), 32'd0);

        for (int i = 1; i <= 10; i++) begin
            miss_pc = 1'b1; frame_tick = i[0]; step();
            miss_pc = 1'b0; frame_tick = 1'b0;
            m_player++; m_dir = 1;
            push(2'd2, 2'b00, 1'b0);
            check_pop("pt");
            if (i == 1) begin
                miss_player = 1'b1; step(); miss_player = 1'b0;
                push(2'd2, 2'b00, 1'b0);
                check_pop("pause_miss_ign");
            end
            if (i == 9)  chk("score9",  32'(score_player), 32'h09);
            if (i == 10) chk("score10", 32'(score_player), 32'h10);
            pause_serve("pt");
        end

        miss_pc = 1'b1; miss_player = 1'b1; step();
        miss_pc = 1'b0; miss_player = 1'b0;
        push(2'd2, 2'b00, 1'b0);
        check_pop("both");
        pause_serve("both");

        miss_player = 1'b1; step(); miss_player = 1'b0;
        m_pc++; m_dir = 0;
        push(2'd2, 2'b00, 1'b0);
        check_pop("pc_pt");
        pause_serve("pc_pt");

        miss_pc = 1'b1; step(); miss_pc = 1'b0;
        m_player++; m_dir = 1;
        push(2'd3, 2'b01, 1'b0);
        check_pop("win");
        chk("win_score", 32'(score_player), 32'h11);

        miss_pc = 1'b1; step(); miss_pc = 1'b0;
        push(2'd3, 2'b01, 1'b0);
        check_pop("over_ign");
        chk("over_noserve", 32'(serve), 32'd0);

        start = 1'b0; step();
        start = 1'b1; step();
        m_player = 0; m_pc = 0;
        push(2'd1, 2'b00, 1'b1);
        check_pop("restart");
        chk("restart_serve", 32'(serve), 32'd1);

        miss_pc = 1'b1; step(); miss_pc = 1'b0;
        m_player = 1;
        push(2'd2, 2'b00, 1'b0);
        check_pop("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        m_player = 0; m_pc = 0; m_dir = 0;
        push(2'd0, 2'b00, 1'b0);
        check_pop("async_rst");
        chk("async_rst_serve", 32'(serve), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_idle", 32'(state), 32'd0);
        chk("post_rst_noserve", 32'(serve), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
